// File: rtl/otter_seq_ctrl.sv
// Multicycle phase sequencer for the OTTER core: drives PC/regfile/memory/CSR enables
// per instruction phase, stalls IOBUS accesses until ready or timeout, and enters interrupts between instructions.
module otter_seq_ctrl #(
    parameter logic [31:0] IO_BASE    = 32'h1100_0000,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic        INTR,
    input  logic        IO_RDY,
    output logic        PCWrite,
    output logic        regWrite,
    output logic        memWE2,
    output logic        memRDEN1,
    output logic        memRDEN2,
    output logic        reset,
    output logic        csr_WE,
    output logic        int_taken,
    output logic        mret_exec,
    output logic        IO_ERR,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_IOWAIT = 3'd4,
        ST_INTR   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Counter only needs to reach IO_TIMEOUT-1; with IO_TIMEOUT=0 it just wraps harmlessly.
    localparam int             CW       = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (IO_TIMEOUT > 0) ? CW'(IO_TIMEOUT - 1) : '0;
    localparam logic           TO_EN    = (IO_TIMEOUT > 0);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_int_pend;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_io_err;

    logic            w_is_io;
    logic            w_timeout;
    logic            w_io_done;
    logic            w_end;

    assign w_is_io   = (addr >= IO_BASE);
    assign w_timeout = TO_EN && (r_wait_cnt == CNT_LAST);
    assign w_io_done = IO_RDY | w_timeout;

    assign IO_ERR = r_io_err;
    assign state  = r_state;

    always_comb begin
        w_state_next = r_state;
        w_end        = 1'b0;
        PCWrite      = 1'b0;
        regWrite     = 1'b0;
        memWE2       = 1'b0;
        memRDEN1     = 1'b0;
        memRDEN2     = 1'b0;
        reset        = 1'b0;
        csr_WE       = 1'b0;
        int_taken    = 1'b0;
        mret_exec    = 1'b0;

        case (r_state)
            ST_INIT: begin
                reset        = 1'b1;
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1     = 1'b1;
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_LOAD: begin
                        memRDEN2     = 1'b1;
                        w_state_next = w_is_io ? ST_IOWAIT : ST_WB;
                    end
                    OP_STORE: begin
                        memWE2 = 1'b1;
                        if (w_is_io) begin
                            w_state_next = ST_IOWAIT;
                        end else begin
                            PCWrite = 1'b1;
                            w_end   = 1'b1;
                        end
                    end
                    OP_SYSTEM: begin
                        PCWrite = 1'b1;
                        w_end   = 1'b1;
                        if (func3 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else begin
                            regWrite = 1'b1;
                            csr_WE   = 1'b1;
                        end
                    end
                    OP_BRANCH: begin
                        PCWrite = 1'b1;
                        w_end   = 1'b1;
                    end
                    OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        regWrite = 1'b1;
                        PCWrite  = 1'b1;
                        w_end    = 1'b1;
                    end
                    default: begin
                        PCWrite = 1'b1;
                        w_end   = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                regWrite = 1'b1;
                PCWrite  = 1'b1;
                w_end    = 1'b1;
            end
            ST_IOWAIT: begin
                if (w_io_done) begin
                    PCWrite  = 1'b1;
                    regWrite = (opcode == OP_LOAD);
                    w_end    = 1'b1;
                end
            end
            ST_INTR: begin
                int_taken    = 1'b1;
                PCWrite      = 1'b1;
                w_state_next = ST_FETCH;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase

        // A live request counts even if it has not been latched into the pending flag yet.
        if (w_end) begin
            w_state_next = (r_int_pend | INTR) ? ST_INTR : ST_FETCH;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= ST_INIT;
            r_int_pend <= 1'b0;
            r_wait_cnt <= '0;
            r_io_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Leaving INTR always clears; a held level source simply re-requests later.
            if (r_state == ST_INTR) begin
                r_int_pend <= 1'b0;
            end else if (INTR) begin
                r_int_pend <= 1'b1;
            end

            if ((r_state == ST_IOWAIT) && !w_io_done) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if ((r_state == ST_IOWAIT) && w_timeout && !IO_RDY) begin
                r_io_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_otter_seq_ctrl.sv
// Directed bench for otter_seq_ctrl: a vector table of single instructions plus
// hand-written IOBUS wait, timeout, interrupt and mid-instruction reset sequences.
module tb_otter_seq_ctrl;

    logic        CLK;
    logic        RST;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic        INTR;
    logic        IO_RDY;
    logic        PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
    logic        reset, csr_WE, int_taken, mret_exec, IO_ERR;
    logic [2:0]  state;

    // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
    logic [8:0]  outs;
    assign outs = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec};

    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_INIT  = 9'b000001000;
    localparam logic [8:0] O_FETCH = 9'b000100000;
    localparam logic [8:0] O_ALU   = 9'b110000000;
    localparam logic [8:0] O_PC    = 9'b100000000;
    localparam logic [8:0] O_LD    = 9'b000010000;
    localparam logic [8:0] O_STPC  = 9'b101000000;
    localparam logic [8:0] O_ST    = 9'b001000000;
    localparam logic [8:0] O_CSR   = 9'b110000100;
    localparam logic [8:0] O_MRET  = 9'b100000001;
    localparam logic [8:0] O_INT   = 9'b100000010;

    otter_seq_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .func3     (func3),
        .addr      (addr),
        .INTR      (INTR),
        .IO_RDY    (IO_RDY),
        .PCWrite   (PCWrite),
        .regWrite  (regWrite),
        .memWE2    (memWE2),
        .memRDEN1  (memRDEN1),
        .memRDEN2  (memRDEN2),
        .reset     (reset),
        .csr_WE    (csr_WE),
        .int_taken (int_taken),
        .mret_exec (mret_exec),
        .IO_ERR    (IO_ERR),
        .state     (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] ad;
        logic [8:0]  exec_out;
        logic [2:0]  nxt;
        logic [8:0]  follow_out;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        logic [8:0] last_out;
        logic       err_first;

        // op, f3, addr, EXEC outputs, state after EXEC, outputs in that follow-up cycle (IO_RDY=1)
        vecs[0]  = '{7'b0010011, 3'd0, 32'h0000_0000, O_ALU,  3'd1, O_NONE}; // ADDI
        vecs[1]  = '{7'b0110011, 3'd0, 32'h0000_0000, O_ALU,  3'd1, O_NONE}; // ADD
        vecs[2]  = '{7'b0110111, 3'd0, 32'h0000_0000, O_ALU,  3'd1, O_NONE}; // LUI
        vecs[3]  = '{7'b1101111, 3'd0, 32'h0000_0000, O_ALU,  3'd1, O_NONE}; // JAL
        vecs[4]  = '{7'b1100011, 3'd1, 32'h0000_0000, O_PC,   3'd1, O_NONE}; // BNE
        vecs[5]  = '{7'b0000011, 3'd2, 32'h0000_6000, O_LD,   3'd3, O_ALU};  // LW mem
        vecs[6]  = '{7'b0000011, 3'd2, 32'h1100_0004, O_LD,   3'd4, O_ALU};  // LW io, ready at once
        vecs[7]  = '{7'b0100011, 3'd2, 32'h0000_6000, O_STPC, 3'd1, O_NONE}; // SW mem
        vecs[8]  = '{7'b0100011, 3'd2, 32'h10FF_FFFC, O_STPC, 3'd1, O_NONE}; // SW just below IO_BASE
        vecs[9]  = '{7'b0100011, 3'd2, 32'h1100_0000, O_ST,   3'd4, O_PC};   // SW at IO_BASE
        vecs[10] = '{7'b1110011, 3'd1, 32'h0000_0000, O_CSR,  3'd1, O_NONE}; // CSRRW
        vecs[11] = '{7'b1110011, 3'd0, 32'h0000_0000, O_MRET, 3'd1, O_NONE}; // MRET
        vecs[12] = '{7'b0000000, 3'd0, 32'h0000_0000, O_PC,   3'd1, O_NONE}; // unknown opcode

        RST = 1'b0; opcode = 7'd0; func3 = 3'd0; addr = 32'd0; INTR = 1'b0; IO_RDY = 1'b0;

        // Reset
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'(outs), 32'(O_INIT));
        chk("rst_ioerr", 32'(IO_ERR), 32'd0);
        RST = 1'b1;
        step();
        chk("rst_fetch_state", 32'(state), 32'd1);
        chk("rst_fetch_outs", 32'(outs), 32'(O_FETCH));
        $display("TXN reset release state=%0d", state);

        // Vector table
        IO_RDY = 1'b1;
        for (int i = 0; i < 13; i++) begin
            opcode = vecs[i].op; func3 = vecs[i].f3; addr = vecs[i].ad;
            #1;
            chk($sformatf("v%0d_fetch_state", i), 32'(state), 32'd1);
            chk($sformatf("v%0d_fetch_outs", i), 32'(outs), 32'(O_FETCH));
            step();
            chk($sformatf("v%0d_exec_state", i), 32'(state), 32'd2);
            chk($sformatf("v%0d_exec_outs", i), 32'(outs), 32'(vecs[i].exec_out));
            step();
            chk($sformatf("v%0d_next_state", i), 32'(state), 32'(vecs[i].nxt));
            if (vecs[i].nxt != 3'd1) begin
                chk($sformatf("v%0d_follow_outs", i), 32'(outs), 32'(vecs[i].follow_out));
                step();
                chk($sformatf("v%0d_end_state", i), 32'(state), 32'd1);
            end
            $display("TXN vec %0d op=%b f3=%0d addr=%h", i, vecs[i].op, vecs[i].f3, vecs[i].ad);
        end

        // LW from IOBUS, ready on the third wait cycle
        IO_RDY = 1'b0; opcode = 7'b0000011; func3 = 3'd2; addr = 32'h1100_0004;
        step();
        chk("lwio_exec_outs", 32'(outs), 32'(O_LD));
        step();
        chk("lwio_w1_state", 32'(state), 32'd4);
        chk("lwio_w1_outs", 32'(outs), 32'(O_NONE));
        step();
        chk("lwio_w2_state", 32'(state), 32'd4);
        chk("lwio_w2_outs", 32'(outs), 32'(O_NONE));
        step();
        IO_RDY = 1'b1;
        #1;
        chk("lwio_w3_state", 32'(state), 32'd4);
        chk("lwio_w3_outs", 32'(outs), 32'(O_ALU));
        step();
        IO_RDY = 1'b0;
        chk("lwio_end_state", 32'(state), 32'd1);
        chk("lwio_ioerr", 32'(IO_ERR), 32'd0);
        $display("TXN lw io with 3 wait cycles");

        // SW to IOBUS with no ready: forced completion after IO_TIMEOUT cycles
        opcode = 7'b0100011; func3 = 3'd2; addr = 32'h1100_0000;
        step();
        chk("swto_exec_outs", 32'(outs), 32'(O_ST));
        step();
        n = 0;
        last_out = O_NONE;
        err_first = IO_ERR;
        while (state == 3'd4 && n < 40) begin
            n++;
            last_out = outs;
            step();
        end
        chk("swto_wait_cycles", 32'(n), 32'd16);
        chk("swto_ioerr_during", 32'(err_first), 32'd0);
        chk("swto_last_outs", 32'(last_out), 32'(O_PC));
        chk("swto_end_state", 32'(state), 32'd1);
        chk("swto_ioerr", 32'(IO_ERR), 32'd1);
        opcode = 7'b0010011; func3 = 3'd0; addr = 32'd0;
        step();
        step();
        chk("swto_ioerr_sticky", 32'(IO_ERR), 32'd1);
        $display("TXN sw io timeout after %0d wait cycles", n);

        // Single-cycle INTR pulse during FETCH of ADD
        opcode = 7'b0110011; INTR = 1'b1;
        step();
        INTR = 1'b0;
        #1;
        chk("intp_exec_state", 32'(state), 32'd2);
        chk("intp_exec_outs", 32'(outs), 32'(O_ALU));
        step();
        chk("intp_intr_state", 32'(state), 32'd5);
        chk("intp_intr_outs", 32'(outs), 32'(O_INT));
        step();
        chk("intp_fetch_state", 32'(state), 32'd1);
        opcode = 7'b0010011;
        step();
        step();
        chk("intp_pend_cleared", 32'(state), 32'd1);
        $display("TXN add with interrupt pulse");

        // MRET with INTR held high; no back-to-back interrupt entry
        opcode = 7'b1110011; func3 = 3'd0; INTR = 1'b1;
        step();
        chk("mret_exec_outs", 32'(outs), 32'(O_MRET));
        step();
        chk("mret_intr_state", 32'(state), 32'd5);
        chk("mret_intr_outs", 32'(outs), 32'(O_INT));
        step();
        INTR = 1'b0;
        chk("mret_fetch_state", 32'(state), 32'd1);
        opcode = 7'b0010011;
        step();
        step();
        chk("mret_pend_cleared", 32'(state), 32'd1);
        $display("TXN mret with interrupt held");

        // Reset asserted in the middle of an IOBUS wait
        opcode = 7'b0000011; func3 = 3'd2; addr = 32'h1100_0004; IO_RDY = 1'b0;
        step();
        step();
        chk("rstio_wait_state", 32'(state), 32'd4);
        step();
        RST = 1'b0;
        step();
        chk("rstio_init_state", 32'(state), 32'd0);
        chk("rstio_ioerr", 32'(IO_ERR), 32'd0);
        chk("rstio_init_outs", 32'(outs), 32'(O_INIT));
        RST = 1'b1;
        step();
        chk("rstio_fetch_state", 32'(state), 32'd1);
        $display("TXN reset during io wait");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
